// File: rtl/sop_response_checker.sv
// Response checker for exhaustive truth-table runs: records the first observed
// output per minterm, counts mismatches against EXPECTED, and reports a verdict.
//
// state     | meaning
// IDLE      | after reset, waiting for start
// COLLECT   | accepting samples until every minterm is covered
// CHECK     | one cycle, verdict computed from captured map and err_count
// DONE      | verdict held until next start
module sop_response_checker #(
    parameter int N_IN = 3,
    parameter logic [(2**N_IN)-1:0] EXPECTED = 8'b0110_0110
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN-1:0]        in_vec,
    input  logic                   in_s,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   captured,
    output logic [(2**N_IN)-1:0]   covered,
    output logic [7:0]             err_count
);

    localparam int W = 2**N_IN;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] captured_q, captured_d;
    logic [W-1:0] covered_q, covered_d;
    logic [7:0]   err_q, err_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic         accept;

    assign in_ready  = (state_q == S_COLLECT);
    assign busy      = (state_q == S_COLLECT) || (state_q == S_CHECK);
    assign accept    = in_valid & in_ready;
    assign done      = done_q;
    assign pass      = pass_q;
    assign captured  = captured_q;
    assign covered   = covered_q;
    assign err_count = err_q;

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        covered_d  = covered_q;
        err_d      = err_q;
        done_d     = done_q;
        pass_d     = pass_q;

        // start outranks a same-cycle accept: the sample is dropped
        if (start) begin
            state_d    = S_COLLECT;
            captured_d = '0;
            covered_d  = '0;
            err_d      = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        if (!covered_q[in_vec]) begin
                            captured_d[in_vec] = in_s;
                            covered_d[in_vec]  = 1'b1;
                        end
                        if ((in_s != EXPECTED[in_vec]) && (err_q != 8'hFF)) begin
                            err_d = err_q + 8'd1;
                        end
                        if (&covered_d) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    pass_d  = (err_q == 8'd0) && (captured_q == EXPECTED);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            captured_q <= '0;
            covered_q  <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            covered_q  <= covered_d;
            err_q      <= err_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

endmodule
